// File: rtl/morse_pkg.sv
// Shared definitions for the Morse/OOK transmitter: state encoding, default timing
// and the standard letter patterns used by the character LUT that feeds morse_tx.
package morse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND   = 2'd1,
      ST_GAP    = 2'd2,
      ST_FINISH = 2'd3
   } morse_state_t;

   localparam int DEF_PAT_W     = 16;
   localparam int DEF_TICK_DIV  = 25000000;
   localparam int DEF_GAP_TICKS = 3;

   // Letter patterns: dot = 1, dash = 111, intra-letter space = 0; sent MSB first.
   localparam logic [15:0] PAT_E = 16'b0000_0000_0000_0001;
   localparam int          LEN_E = 1;
   localparam logic [15:0] PAT_T = 16'b0000_0000_0000_0111;
   localparam int          LEN_T = 3;
   localparam logic [15:0] PAT_A = 16'b0000_0000_0001_0111;
   localparam int          LEN_A = 5;
   localparam logic [15:0] PAT_N = 16'b0000_0000_0001_1101;
   localparam int          LEN_N = 5;
   localparam logic [15:0] PAT_S = 16'b0000_0000_0001_0101;
   localparam int          LEN_S = 5;
   localparam logic [15:0] PAT_O = 16'b0000_0111_0111_0111;
   localparam int          LEN_O = 11;

endpackage

// File: rtl/morse_tx_if.sv
// Request/status bundle between a pattern source (master) and morse_tx (slave).
interface morse_tx_if
   import morse_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W
);
   localparam int LEN_W = $clog2(PAT_W + 1);

   logic             start;
   logic             abort;
   logic             repeat_en;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] len;
   logic             out;
   logic             busy;
   logic             done;

   modport master (
      output start, abort, repeat_en, pattern, len,
      input  out, busy, done
   );

   modport slave (
      input  start, abort, repeat_en, pattern, len,
      output out, busy, done
   );

endinterface

// File: rtl/morse_tx_tick_gen.sv
// Bit-rate divider: down-counter reloading at TICK_DIV-1, one-cycle tick at zero.
module tick_gen
   import morse_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);
   localparam int              CNT_W  = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clear || (cnt_q == '0)) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Suppressed while held clear so the post-reset zero never produces a tick.
   assign tick = !clear && (cnt_q == '0);

endmodule

// File: rtl/morse_tx.sv
// Morse/OOK serial transmitter: shifts a latched pattern out MSB-first, one bit per
// divider tick, with an optional low gap and repeat until abort.
//
//   state  | meaning
//   IDLE   | waiting for start; out low, divider held at reload
//   SEND   | driving current pattern bit, advance on each tick
//   GAP    | out low for GAP_TICKS ticks, then repeat or finish
//   FINISH | one-cycle done pulse, busy low, back to IDLE
module morse_tx
   import morse_pkg::*;
#(
   parameter int PAT_W     = DEF_PAT_W,
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int GAP_TICKS = DEF_GAP_TICKS
) (
   input  logic       clock,
   input  logic       reset_n,
   morse_tx_if.slave  bus
);
   localparam int               LEN_W    = $clog2(PAT_W + 1);
   localparam int               GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);

   morse_state_t     state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [PAT_W-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] bitcnt_q, bitcnt_d;
   logic [GAP_W-1:0] gapcnt_q, gapcnt_d;
   logic             out_q, out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [LEN_W-1:0] len_sat;
   logic [PAT_W-1:0] pat_aligned;
   logic             tick;
   logic             div_clear;

   assign div_clear = (state_q == ST_IDLE) || (state_q == ST_FINISH) || bus.abort;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (div_clear),
      .tick    (tick)
   );

   // Left-justify the pattern so bit len-1 lands in the MSB of the shift register.
   assign len_sat     = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
   assign pat_aligned = bus.pattern << (LEN_MAX - len_sat);

   always_comb begin
      state_d  = state_q;
      pat_d    = pat_q;
      shreg_d  = shreg_q;
      len_d    = len_q;
      bitcnt_d = bitcnt_q;
      gapcnt_d = gapcnt_q;
      out_d    = out_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      if (bus.abort) begin
         state_d = ST_IDLE;
         out_d   = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               out_d  = 1'b0;
               busy_d = 1'b0;
               if (bus.start) begin
                  if (len_sat != '0) begin
                     pat_d    = pat_aligned;
                     shreg_d  = pat_aligned;
                     len_d    = len_sat;
                     bitcnt_d = len_sat - LEN_W'(1);
                     out_d    = pat_aligned[PAT_W-1];
                     busy_d   = 1'b1;
                     state_d  = ST_SEND;
                  end else begin
                     done_d  = 1'b1;
                     state_d = ST_FINISH;
                  end
               end
            end
            ST_SEND: begin
               if (tick) begin
                  if (bitcnt_q == '0) begin
                     out_d = 1'b0;
                     if (GAP_TICKS == 0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_FINISH;
                     end else begin
                        gapcnt_d = GAP_LOAD;
                        state_d  = ST_GAP;
                     end
                  end else begin
                     shreg_d  = shreg_q << 1;
                     bitcnt_d = bitcnt_q - LEN_W'(1);
                     out_d    = shreg_q[PAT_W-2];
                  end
               end
            end
            ST_GAP: begin
               out_d = 1'b0;
               if (tick) begin
                  if (gapcnt_q == '0) begin
                     if (bus.repeat_en) begin
                        shreg_d  = pat_q;
                        bitcnt_d = len_q - LEN_W'(1);
                        out_d    = pat_q[PAT_W-1];
                        state_d  = ST_SEND;
                     end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_FINISH;
                     end
                  end else begin
                     gapcnt_d = gapcnt_q - GAP_W'(1);
                  end
               end
            end
            ST_FINISH: begin
               out_d   = 1'b0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
            default: begin
               out_d   = 1'b0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         pat_q    <= '0;
         shreg_q  <= '0;
         len_q    <= '0;
         bitcnt_q <= '0;
         gapcnt_q <= '0;
         out_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pat_q    <= pat_d;
         shreg_q  <= shreg_d;
         len_q    <= len_d;
         bitcnt_q <= bitcnt_d;
         gapcnt_q <= gapcnt_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
